// File: rtl/logic_gate_using_mux_pkg.sv
// Shared constants for the mux-built logic unit.
package logic_gate_using_mux_pkg;

  // Default lane count; every operand and output is this wide.
  localparam int DEFAULT_WIDTH = 1;

endpackage : logic_gate_using_mux_pkg

// File: rtl/logic_gate_using_mux_if.sv
// Operand/result bundle for the mux-built logic unit. The master drives A/B and
// observes the seven registered results. The slave is the logic unit itself.
interface logic_gate_using_mux_if #(
  parameter int WIDTH = logic_gate_using_mux_pkg::DEFAULT_WIDTH
);

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] notout;
  logic [WIDTH-1:0] andout;
  logic [WIDTH-1:0] orout;
  logic [WIDTH-1:0] xorout;
  logic [WIDTH-1:0] xnorout;
  logic [WIDTH-1:0] nandout;
  logic [WIDTH-1:0] norout;

  modport master (
    output A, B,
    input  notout, andout, orout, xorout, xnorout, nandout, norout
  );

  modport slave (
    input  A, B,
    output notout, andout, orout, xorout, xnorout, nandout, norout
  );

endinterface : logic_gate_using_mux_if

// File: rtl/logic_gate_using_mux_mux2.sv
// One-bit 2:1 multiplexer. This is the only primitive the logic unit is built from.
module logic_gate_using_mux_mux2 (
  input  logic s_i,
  input  logic d0_i,
  input  logic d1_i,
  output logic y_o
);

  // Select d1 when s is high, otherwise d0.
  assign y_o = s_i ? d1_i : d0_i;

endmodule : logic_gate_using_mux_mux2

// File: rtl/logic_gate_using_mux.sv
// Bitwise two-input logic unit. Every function is a 2:1 mux selected by A, with
// B or its mux-built complement on the data legs. All seven results are registered.
module logic_gate_using_mux
  import logic_gate_using_mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  logic_gate_using_mux_if.slave  bus
);

  // Complement of B. This is the only mux whose select is not A.
  logic [WIDTH-1:0] nb;

  // Combinational function results (next-state of the output bank).
  logic [WIDTH-1:0] not_d;
  logic [WIDTH-1:0] and_d;
  logic [WIDTH-1:0] or_d;
  logic [WIDTH-1:0] nand_d;
  logic [WIDTH-1:0] nor_d;
  logic [WIDTH-1:0] xor_d;
  logic [WIDTH-1:0] xnor_d;

  // Registered outputs.
  logic [WIDTH-1:0] not_q;
  logic [WIDTH-1:0] and_q;
  logic [WIDTH-1:0] or_q;
  logic [WIDTH-1:0] nand_q;
  logic [WIDTH-1:0] nor_q;
  logic [WIDTH-1:0] xor_q;
  logic [WIDTH-1:0] xnor_q;

  // Eight muxes per lane. Lanes never interact.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
    logic_gate_using_mux_mux2 u_nb (
      .s_i(bus.B[gi]), .d0_i(1'b1), .d1_i(1'b0), .y_o(nb[gi])
    );
    logic_gate_using_mux_mux2 u_not (
      .s_i(bus.A[gi]), .d0_i(1'b1), .d1_i(1'b0), .y_o(not_d[gi])
    );
    logic_gate_using_mux_mux2 u_and (
      .s_i(bus.A[gi]), .d0_i(1'b0), .d1_i(bus.B[gi]), .y_o(and_d[gi])
    );
    logic_gate_using_mux_mux2 u_or (
      .s_i(bus.A[gi]), .d0_i(bus.B[gi]), .d1_i(1'b1), .y_o(or_d[gi])
    );
    logic_gate_using_mux_mux2 u_nand (
      .s_i(bus.A[gi]), .d0_i(1'b1), .d1_i(nb[gi]), .y_o(nand_d[gi])
    );
    logic_gate_using_mux_mux2 u_nor (
      .s_i(bus.A[gi]), .d0_i(nb[gi]), .d1_i(1'b0), .y_o(nor_d[gi])
    );
    logic_gate_using_mux_mux2 u_xor (
      .s_i(bus.A[gi]), .d0_i(bus.B[gi]), .d1_i(nb[gi]), .y_o(xor_d[gi])
    );
    logic_gate_using_mux_mux2 u_xnor (
      .s_i(bus.A[gi]), .d0_i(nb[gi]), .d1_i(bus.B[gi]), .y_o(xnor_d[gi])
    );
  end : g_lane

  // Output bank: one-cycle latency. Reset clears every output to zero,
  // including the functions that would naturally be 1 at A=B=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      not_q  <= '0;
      and_q  <= '0;
      or_q   <= '0;
      nand_q <= '0;
      nor_q  <= '0;
      xor_q  <= '0;
      xnor_q <= '0;
    end else begin
      not_q  <= not_d;
      and_q  <= and_d;
      or_q   <= or_d;
      nand_q <= nand_d;
      nor_q  <= nor_d;
      xor_q  <= xor_d;
      xnor_q <= xnor_d;
    end
  end

  assign bus.notout  = not_q;
  assign bus.andout  = and_q;
  assign bus.orout   = or_q;
  assign bus.nandout = nand_q;
  assign bus.norout  = nor_q;
  assign bus.xorout  = xor_q;
  assign bus.xnorout = xnor_q;

endmodule : logic_gate_using_mux

// File: tb/tb_logic_gate_using_mux.sv
// Bench for the mux-built logic unit: a 1-bit and a 4-bit instance share clock
// and reset; results are compared with a plain-operator reference model.
module tb_logic_gate_using_mux;

  logic clk;
  logic rst_n;

  int n_asserts;
  int n_fails;

  logic_gate_using_mux_if #(.WIDTH(1)) if1 ();
  logic_gate_using_mux_if #(.WIDTH(4)) if4 ();

  logic_gate_using_mux #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  logic_gate_using_mux #(.WIDTH(4)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: seven 4-bit fields {not,and,or,nand,nor,xor,xnor}, masked to w lanes.
  function automatic logic [27:0] ref_model(input logic [3:0] a, input logic [3:0] b, input int w);
    logic [3:0] m;
    m = 4'((1 << w) - 1);
    a = a & m;
    b = b & m;
    return {~a & m, a & b, a | b, ~(a & b) & m, ~(a | b) & m, a ^ b, ~(a ^ b) & m};
  endfunction

  // Compare all seven outputs of the selected instance against exp.
  task automatic compare(input string tag, input int w, input logic [27:0] exp);
    logic [27:0] obs;
    string names [7];
    names = '{"xnor", "xor", "nor", "nand", "or", "and", "not"};
    if (w == 1)
      obs = {3'b0, if1.notout, 3'b0, if1.andout, 3'b0, if1.orout, 3'b0, if1.nandout,
             3'b0, if1.norout, 3'b0, if1.xorout, 3'b0, if1.xnorout};
    else
      obs = {if4.notout, if4.andout, if4.orout, if4.nandout,
             if4.norout, if4.xorout, if4.xnorout};
    for (int k = 0; k < 7; k++) begin
      n_asserts++;
      assert (obs[k*4 +: 4] === exp[k*4 +: 4]) else begin
        n_fails++;
        $display("FAIL %s w%0d %s: got %b expected %b", tag, w, names[k],
                 obs[k*4 +: 4], exp[k*4 +: 4]);
        $error("%s w%0d %s mismatch", tag, w, names[k]);
      end
    end
  endtask

  logic [3:0] a1, b1, a4, b4;

  // Drive new operands between edges, then check one edge later.
  task automatic step(input string tag, input logic [3:0] na1, input logic [3:0] nb1,
                      input logic [3:0] na4, input logic [3:0] nb4);
    @(negedge clk);
    a1 = na1; b1 = nb1; a4 = na4; b4 = nb4;
    if1.A = a1[0]; if1.B = b1[0];
    if4.A = a4;    if4.B = b4;
    @(posedge clk);
    #1;
    compare(tag, 1, ref_model(a1, b1, 1));
    compare(tag, 4, ref_model(a4, b4, 4));
  endtask

  initial begin
    n_asserts = 0;
    n_fails   = 0;
    rst_n = 1'b1;
    a1 = '0; b1 = '0; a4 = '0; b4 = '0;
    if1.A = '0; if1.B = '0; if4.A = '0; if4.B = '0;

    // Asynchronous reset away from any edge.
    #3 rst_n = 1'b0;
    #1;
    compare("rst_async", 1, 28'b0);
    compare("rst_async", 4, 28'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compare("rst_hold", 1, 28'b0);
    @(posedge clk);
    #1;
    compare("rst_first", 1, ref_model(4'h0, 4'h0, 1));
    compare("rst_first", 4, ref_model(4'h0, 4'h0, 4));

    // Truth table, back-to-back on consecutive edges.
    step("tt01", 4'h0, 4'h1, 4'h0, 4'h0);
    step("tt10", 4'h1, 4'h0, 4'h0, 4'h0);
    step("tt11", 4'h1, 4'h1, 4'h0, 4'h0);
    step("b2b00", 4'h0, 4'h0, 4'h0, 4'h0);
    step("b2b01", 4'h0, 4'h1, 4'h0, 4'h0);
    step("b2b10", 4'h1, 4'h0, 4'h0, 4'h0);
    step("b2b11", 4'h1, 4'h1, 4'h0, 4'h0);

    // Latency: A rises mid-cycle; outputs must not move until the next edge.
    step("lat_pre", 4'h0, 4'h1, 4'h0, 4'h0);
    @(negedge clk);
    if1.A = 1'b1;
    #1;
    compare("lat_mid", 1, ref_model(4'h0, 4'h1, 1));
    a1 = 4'h1;
    @(posedge clk);
    #1;
    compare("lat_post", 1, ref_model(4'h1, 4'h1, 1));

    // Reset pulse between edges while A=B=1.
    step("mrst_pre", 4'h1, 4'h1, 4'hF, 4'hF);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    compare("mrst_low", 1, 28'b0);
    compare("mrst_low", 4, 28'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    compare("mrst_rec", 1, ref_model(4'h1, 4'h1, 1));
    compare("mrst_rec", 4, ref_model(4'hF, 4'hF, 4));

    // Four-lane directed pattern.
    step("w4dir", 4'h0, 4'h0, 4'b1100, 4'b1010);

    // Randomized operands on both instances.
    for (int i = 0; i < 200; i++) begin
      step("rand", 4'($urandom_range(0, 1)), 4'($urandom_range(0, 1)),
           4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule : tb_logic_gate_using_mux
